// File: rtl/pc_sequencer.sv
// Fetch PC owner: selects the next PC from sequential, branch, jump and trap sources
// and sequences the flush of the younger IF/ID stages after every redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_offset_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        trap_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        redirect_o,
    output logic        flush_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_cnt;
    logic        r_redirect;
    logic        r_flush;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_redirect_nxt;
    logic        w_flush_nxt;
    logic        w_valid_nxt;

    logic [31:0] w_br_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_target;
    logic        w_redir;

    assign w_br_target = br_pc_i + br_offset_i;
    assign w_seq_pc    = r_pc + 32'd4;

    // Redirect source in priority order; HALT only honours trap.
    always_comb begin
        w_redir  = 1'b0;
        w_target = r_pc;
        if (r_state == S_RUN || r_state == S_FLUSH) begin
            if (trap_i) begin
                w_redir  = 1'b1;
                w_target = TRAP_VECTOR;
            end else if (br_taken_i) begin
                w_redir  = 1'b1;
                w_target = w_br_target;
            end else if (jmp_i) begin
                w_redir  = 1'b1;
                w_target = jmp_target_i;
            end
        end else if (r_state == S_HALT && trap_i) begin
            w_redir  = 1'b1;
            w_target = TRAP_VECTOR;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_redirect_nxt = 1'b0;
        w_flush_nxt    = r_flush;
        w_valid_nxt    = r_valid;

        if (w_redir) begin
            w_state_nxt    = S_FLUSH;
            w_pc_nxt       = {w_target[31:2], 2'b00};
            w_cnt_nxt      = CNT_LOAD;
            w_redirect_nxt = 1'b1;
            w_flush_nxt    = 1'b1;
            w_valid_nxt    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_RUN;
                    w_valid_nxt = 1'b1;
                end
                S_RUN: begin
                    if (halt_i) begin
                        w_state_nxt = S_HALT;
                        w_valid_nxt = 1'b0;
                    end else if (!stall_i) begin
                        w_pc_nxt = w_seq_pc;
                    end
                end
                S_FLUSH: begin
                    if (!stall_i) begin
                        w_pc_nxt = w_seq_pc;
                    end
                    // Counter runs during stalls so flush length is fixed in cycles.
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = S_RUN;
                        w_flush_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                S_HALT: begin
                    if (resume_i) begin
                        w_state_nxt = S_RUN;
                        w_valid_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_cnt      <= '0;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_redirect <= w_redirect_nxt;
            r_flush    <= w_flush_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_valid;
    assign redirect_o = r_redirect;
    assign flush_o    = r_flush;
    assign state_o    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: each vector drives one edge, expected
// outputs go through a scoreboard queue and are compared after the edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_pc_i;
    logic [31:0] br_offset_i;
    logic        jmp_i;
    logic [31:0] jmp_target_i;
    logic        trap_i;
    logic        halt_i;
    logic        resume_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        redirect_o;
    logic        flush_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0080),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_pc_i     (br_pc_i),
        .br_offset_i (br_offset_i),
        .jmp_i       (jmp_i),
        .jmp_target_i(jmp_target_i),
        .trap_i      (trap_i),
        .halt_i      (halt_i),
        .resume_i    (resume_i),
        .pc_o        (pc_o),
        .pc_valid_o  (pc_valid_o),
        .redirect_o  (redirect_o),
        .flush_o     (flush_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_pc;
        logic [31:0] br_off;
        logic        jmp;
        logic [31:0] jmp_tgt;
        logic        trap;
        logic        halt;
        logic        resume;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_red;
        logic        e_flush;
        logic [1:0]  e_state;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        valid;
        logic        red;
        logic        flush;
        logic [1:0]  state;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic stall, input logic br, input logic [31:0] br_pc, input logic [31:0] br_off,
        input logic jmp, input logic [31:0] jmp_tgt, input logic trap, input logic halt,
        input logic resume, input logic [31:0] e_pc, input logic e_valid, input logic e_red,
        input logic e_flush, input logic [1:0] e_state);
        vec_t v;
        v.stall = stall;  v.br = br;  v.br_pc = br_pc;  v.br_off = br_off;
        v.jmp = jmp;  v.jmp_tgt = jmp_tgt;  v.trap = trap;  v.halt = halt;
        v.resume = resume;  v.e_pc = e_pc;  v.e_valid = e_valid;  v.e_red = e_red;
        v.e_flush = e_flush;  v.e_state = e_state;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [31:0] pc, input logic valid,
                             input logic red, input logic flush, input logic [1:0] st);
        check("pc_o", idx, pc_o, pc);
        check("pc_valid_o", idx, {31'd0, pc_valid_o}, {31'd0, valid});
        check("redirect_o", idx, {31'd0, redirect_o}, {31'd0, red});
        check("flush_o", idx, {31'd0, flush_o}, {31'd0, flush});
        check("state_o", idx, {30'd0, state_o}, {30'd0, st});
    endtask

    task automatic idle_inputs();
        stall_i = 0; br_taken_i = 0; br_pc_i = '0; br_offset_i = '0;
        jmp_i = 0; jmp_target_i = '0; trap_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        stall_i = v.stall; br_taken_i = v.br; br_pc_i = v.br_pc; br_offset_i = v.br_off;
        jmp_i = v.jmp; jmp_target_i = v.jmp_tgt; trap_i = v.trap; halt_i = v.halt;
        resume_i = v.resume;
        e.idx = idx; e.pc = v.e_pc; e.valid = v.e_valid; e.red = v.e_red;
        e.flush = v.e_flush; e.state = v.e_state;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard[%0d]: got empty queue expected 1 entry", idx);
        end else begin
            e = sb.pop_front();
            check_all(e.idx, e.pc, e.valid, e.red, e.flush, e.state);
        end
    endtask

    localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_FLUSH = 2'b10, ST_HALT = 2'b11;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          stl br brpc          broff         jmp jtgt          trp hlt res  e_pc          v  r  f  st
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0008, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 32'h40,       32'hFFFF_FFF0, 0, 32'h0,       0, 0, 0, 32'h0000_0030, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0034, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0038, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 32'h100,      32'h10,       1, 32'h300,      1, 0, 0, 32'h0000_0080, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0088, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,        1, 32'h203,      0, 0, 0, 32'h0000_0200, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0200, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0200, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0200, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0204, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFF0, 32'h20,      0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        1, 32'h500,      0, 0, 0, 32'h0000_0500, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_0504, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_0508, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_0508, 0, 0, 0, ST_HALT));
        tbl.push_back(mk(1, 1, 32'h40,       32'h40,       1, 32'h600,      0, 0, 0, 32'h0000_0508, 0, 0, 0, ST_HALT));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0508, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_050C, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_050C, 0, 0, 0, ST_HALT));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_0080, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0088, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        1, 32'h700,      0, 1, 0, 32'h0000_0700, 1, 1, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0704, 1, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0708, 1, 0, 0, ST_RUN));

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(1000, 32'h0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset landing mid-flush must clear outputs without waiting for an edge.
        apply(mk(0, 1, 32'h1000, 32'h4, 0, 32'h0, 0, 0, 0, 32'h0000_1004, 1, 1, 1, ST_FLUSH), 2000);
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        check_all(2001, 32'h0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        #2;
        rst = 1'b0;
        apply(mk(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, ST_RUN), 2002);
        apply(mk(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0000_0004, 1, 0, 0, ST_RUN), 2003);
        apply(mk(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0000_0008, 1, 0, 0, ST_RUN), 2004);

        // Reset while halted.
        apply(mk(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0000_0008, 0, 0, 0, ST_HALT), 2005);
        #2;
        rst = 1'b1;
        #1;
        check_all(2006, 32'h0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        rst = 1'b0;
        apply(mk(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, ST_RUN), 2007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
